// File: rtl/fp_pkg.sv
// Shared types and constant helpers for the parametrised floating-point units.
package fp_pkg;

  // Sequencer states of the iterative multiplier.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    MULT   = 3'd2,
    NORM   = 3'd3,
    ROUND  = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Operand classes; denormals are folded into ZERO.
  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    NORMAL = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } fp_class_t;

  // Exponent bias for an ew-bit exponent field: 2^(ew-1) - 1.
  function automatic int fp_bias(input int ew);
    return (32'sd1 << (ew - 1)) - 32'sd1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [63:0] fp_qnan(input int ew, input int mw);
    logic [63:0] q;
    q = 64'd0;
    for (int i = 0; i < ew; i++) begin
      q[mw + i] = 1'b1;
    end
    q[mw - 1] = 1'b1;
    return q;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Splits one operand into sign, exponent and significand (hidden bit restored)
// and classifies it. Denormals are reported as ZERO with a zero significand.
module fp_classify import fp_pkg::*; #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic [EW+MW:0] op,
  output logic           sign,
  output logic [EW-1:0]  exp,
  output logic [MW:0]    sig,
  output fp_class_t      cls
);

  // Field extraction and class decode.
  always_comb begin
    sign = op[EW+MW];
    exp  = op[EW+MW-1:MW];
    sig  = {(MW+1){1'b0}};
    cls  = ZERO;
    if (op[EW+MW-1:MW] == {EW{1'b0}}) begin
      cls = ZERO;
    end else if (op[EW+MW-1:MW] == {EW{1'b1}}) begin
      if (op[MW-1:0] == {MW{1'b0}}) begin
        cls = INF;
      end else begin
        cls = NAN;
      end
    end else begin
      cls = NORMAL;
      sig = {1'b1, op[MW-1:0]};
    end
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential floating-point multiplier: one shift-add step per cycle on the
// significands, then normalisation and round-to-nearest-even. Result and flags
// are committed together with a one-cycle ready pulse.
module fp_mul_seq import fp_pkg::*; #(
  parameter  int EW = 8,
  parameter  int MW = 23,
  localparam int W  = 1 + EW + MW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] Y,
  output logic         ready,
  output logic         busy,
  output logic         overflow,
  output logic         underflow,
  output logic         invalid
);

  localparam int PW = 2 * (MW + 1);
  localparam int XW = EW + 2;
  localparam int CW = $clog2(MW + 1);
  localparam logic signed [XW-1:0] BIAS_X  = XW'(fp_bias(EW));
  localparam logic signed [XW-1:0] EMAX_X  = {2'b00, {EW{1'b1}}};
  localparam logic signed [XW-1:0] ONE_X   = {{(XW-1){1'b0}}, 1'b1};
  localparam logic        [W-1:0]  QNAN    = W'(fp_qnan(EW, MW));

  state_t state_r, state_s;

  logic [W-1:0]  a_r, b_r;
  logic [PW-1:0] prod_r;
  logic [MW:0]   mcand_r;
  logic [CW-1:0] cnt_r;
  logic signed [XW-1:0] exp_r;
  logic          sign_r;
  logic [MW:0]   mant_r;
  logic          guard_r, sticky_r;
  logic [W-1:0]  res_r;
  logic          res_ov_r, res_un_r, res_inv_r;
  logic [W-1:0]  y_r;
  logic          ready_r, busy_r, ov_r, un_r, inv_r;

  logic          sign_a, sign_b, sign_s;
  logic [EW-1:0] exp_a, exp_b;
  logic [MW:0]   sig_a, sig_b;
  fp_class_t     cls_a, cls_b;

  logic          accept_s;
  logic          special_s, spec_inv_s;
  logic [W-1:0]  spec_res_s;
  logic [MW:0]   norm_mant_s;
  logic          norm_guard_s, norm_sticky_s;
  logic signed [XW-1:0] norm_exp_s;
  logic          inc_s;
  logic [MW+1:0] sum_s;
  logic [MW-1:0] frac_s;
  logic signed [XW-1:0] rexp_s;
  logic [W-1:0]  round_res_s;
  logic          round_ov_s, round_un_s;

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole register right.
  function automatic logic [PW-1:0] mul_step(input logic [PW-1:0] p, input logic [MW:0] m);
    logic [MW+1:0] acc;
    acc = {1'b0, p[PW-1:MW+1]} + (p[0] ? {1'b0, m} : {(MW+2){1'b0}});
    return {acc, p[MW:1]};
  endfunction

  fp_classify #(.EW(EW), .MW(MW)) u_cls_a (
    .op(a_r), .sign(sign_a), .exp(exp_a), .sig(sig_a), .cls(cls_a)
  );

  fp_classify #(.EW(EW), .MW(MW)) u_cls_b (
    .op(b_r), .sign(sign_b), .exp(exp_b), .sig(sig_b), .cls(cls_b)
  );

  assign sign_s   = sign_a ^ sign_b;
  assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));

  // Next-state logic; MULT holds for MW cycles because the first of the
  // MW+1 shift-add steps is taken on the way out of UNPACK.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = UNPACK;
        else          state_s = IDLE;
      end
      UNPACK: begin
        if (special_s) state_s = DONE;
        else           state_s = MULT;
      end
      MULT: begin
        if (cnt_r == CW'(MW - 1)) state_s = NORM;
        else                      state_s = MULT;
      end
      NORM:  state_s = ROUND;
      ROUND: state_s = DONE;
      DONE: begin
        if (accept_s) state_s = UNPACK;
        else          state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Special-operand results (NaN, infinity, zero) that bypass the datapath.
  always_comb begin
    special_s  = 1'b0;
    spec_inv_s = 1'b0;
    spec_res_s = {W{1'b0}};
    if ((cls_a == NAN) || (cls_b == NAN) ||
        ((cls_a == INF) && (cls_b == ZERO)) || ((cls_a == ZERO) && (cls_b == INF))) begin
      special_s  = 1'b1;
      spec_inv_s = 1'b1;
      spec_res_s = QNAN;
    end else if ((cls_a == INF) || (cls_b == INF)) begin
      special_s  = 1'b1;
      spec_res_s = {sign_s, {EW{1'b1}}, {MW{1'b0}}};
    end else if ((cls_a == ZERO) || (cls_b == ZERO)) begin
      special_s  = 1'b1;
      spec_res_s = {sign_s, {(EW+MW){1'b0}}};
    end else begin
      special_s  = 1'b0;
      spec_res_s = {W{1'b0}};
    end
  end

  // Normalisation: a product in [2,4) drops one more bit and bumps the exponent.
  always_comb begin
    norm_mant_s   = prod_r[PW-2:MW];
    norm_guard_s  = prod_r[MW-1];
    norm_sticky_s = |prod_r[MW-2:0];
    norm_exp_s    = exp_r;
    if (prod_r[PW-1]) begin
      norm_mant_s   = prod_r[PW-1:MW+1];
      norm_guard_s  = prod_r[MW];
      norm_sticky_s = |prod_r[MW-1:0];
      norm_exp_s    = exp_r + ONE_X;
    end else begin
      norm_mant_s   = prod_r[PW-2:MW];
      norm_guard_s  = prod_r[MW-1];
      norm_sticky_s = |prod_r[MW-2:0];
      norm_exp_s    = exp_r;
    end
  end

  // Round to nearest even, renormalise on carry-out, then saturate or flush.
  always_comb begin
    inc_s = guard_r & (sticky_r | mant_r[0]);
    sum_s = {1'b0, mant_r} + {{(MW+1){1'b0}}, inc_s};
    if (sum_s[MW+1]) begin
      frac_s = sum_s[MW:1];
      rexp_s = exp_r + ONE_X;
    end else begin
      frac_s = sum_s[MW-1:0];
      rexp_s = exp_r;
    end
    round_ov_s  = 1'b0;
    round_un_s  = 1'b0;
    round_res_s = {sign_r, rexp_s[EW-1:0], frac_s};
    if (rexp_s >= EMAX_X) begin
      round_ov_s  = 1'b1;
      round_res_s = {sign_r, {EW{1'b1}}, {MW{1'b0}}};
    end else if (rexp_s <= $signed({XW{1'b0}})) begin
      round_un_s  = 1'b1;
      round_res_s = {sign_r, {(EW+MW){1'b0}}};
    end else begin
      round_res_s = {sign_r, rexp_s[EW-1:0], frac_s};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Operand capture and per-state datapath updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= {W{1'b0}};
      b_r       <= {W{1'b0}};
      prod_r    <= {PW{1'b0}};
      mcand_r   <= {(MW+1){1'b0}};
      cnt_r     <= {CW{1'b0}};
      exp_r     <= {XW{1'b0}};
      sign_r    <= 1'b0;
      mant_r    <= {(MW+1){1'b0}};
      guard_r   <= 1'b0;
      sticky_r  <= 1'b0;
      res_r     <= {W{1'b0}};
      res_ov_r  <= 1'b0;
      res_un_r  <= 1'b0;
      res_inv_r <= 1'b0;
    end else begin
      if (accept_s) begin
        a_r <= A;
        b_r <= B;
      end
      case (state_r)
        UNPACK: begin
          prod_r    <= mul_step({{(MW+1){1'b0}}, sig_b}, sig_a);
          mcand_r   <= sig_a;
          cnt_r     <= {CW{1'b0}};
          exp_r     <= $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_X;
          sign_r    <= sign_s;
          res_r     <= spec_res_s;
          res_inv_r <= spec_inv_s;
          res_ov_r  <= 1'b0;
          res_un_r  <= 1'b0;
        end
        MULT: begin
          prod_r <= mul_step(prod_r, mcand_r);
          cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
        NORM: begin
          mant_r   <= norm_mant_s;
          guard_r  <= norm_guard_s;
          sticky_r <= norm_sticky_s;
          exp_r    <= norm_exp_s;
        end
        ROUND: begin
          res_r    <= round_res_s;
          res_ov_r <= round_ov_s;
          res_un_r <= round_un_s;
        end
        default: begin
        end
      endcase
    end
  end

  // Registered outputs: result and flags commit as DONE ends, with ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r     <= {W{1'b0}};
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      ov_r    <= 1'b0;
      un_r    <= 1'b0;
      inv_r   <= 1'b0;
    end else begin
      ready_r <= (state_r == DONE);
      busy_r  <= (state_r == UNPACK) || (state_r == MULT) ||
                 (state_r == NORM)   || (state_r == ROUND);
      if (state_r == DONE) begin
        y_r   <= res_r;
        ov_r  <= res_ov_r;
        un_r  <= res_un_r;
        inv_r <= res_inv_r;
      end else if (accept_s) begin
        ov_r  <= 1'b0;
        un_r  <= 1'b0;
        inv_r <= 1'b0;
      end
    end
  end

  assign Y         = y_r;
  assign ready     = ready_r;
  assign busy      = busy_r;
  assign overflow  = ov_r;
  assign underflow = un_r;
  assign invalid   = inv_r;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq: float32 and EW=5/MW=10 instances against an
// integer-arithmetic reference of the multiply/round/range rules.
module tb_fp_mul_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s32, r32, bz32, ov32, un32, iv32;
  logic [31:0] a32, b32, y32;
  logic        s16, r16, bz16, ov16, un16, iv16;
  logic [15:0] a16, b16, y16;

  fp_mul_seq #(.EW(8), .MW(23)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(s32), .A(a32), .B(b32), .Y(y32),
    .ready(r32), .busy(bz32), .overflow(ov32), .underflow(un32), .invalid(iv32)
  );

  fp_mul_seq #(.EW(5), .MW(10)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .A(a16), .B(b16), .Y(y16),
    .ready(r16), .busy(bz16), .overflow(ov16), .underflow(un16), .invalid(iv16)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: exact integer product, rounded by remainder comparison.
  function automatic void ref_mul(input int ew, input int mw, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] y,
                                  output bit ov, output bit un, output bit inv, output bit sp);
    longint one = 1;
    longint emax, bias, ea, eb, fa, fb, s, p, q, rem, half, e;
    bit za, zb, ia, ib, na, nb;
    int sh;
    emax = (one << ew) - 1;
    bias = (one << (ew - 1)) - 1;
    s  = ((longint'(a) >> (ew + mw)) ^ (longint'(b) >> (ew + mw))) & 1;
    ea = (longint'(a) >> mw) & emax;
    eb = (longint'(b) >> mw) & emax;
    fa = longint'(a) & ((one << mw) - 1);
    fb = longint'(b) & ((one << mw) - 1);
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == emax) && (fa == 0); ib = (eb == emax) && (fb == 0);
    na = (ea == emax) && (fa != 0); nb = (eb == emax) && (fb != 0);
    ov = 0; un = 0; inv = 0; sp = 1;
    if (na || nb || (ia && zb) || (ib && za)) begin
      y = 32'((emax << mw) | (one << (mw - 1)));
      inv = 1;
    end else if (ia || ib) begin
      y = 32'((s << (ew + mw)) | (emax << mw));
    end else if (za || zb) begin
      y = 32'(s << (ew + mw));
    end else begin
      sp = 0;
      p  = ((one << mw) | fa) * ((one << mw) | fb);
      e  = ea + eb - bias;
      sh = mw;
      if (p >= (one << (2 * mw + 1))) begin
        sh = mw + 1;
        e++;
      end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = one << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (one << (mw + 1))) begin
        q = q >> 1;
        e++;
      end
      if (e >= emax) begin
        y  = 32'((s << (ew + mw)) | (emax << mw));
        ov = 1;
      end else if (e <= 0) begin
        y  = 32'(s << (ew + mw));
        un = 1;
      end else begin
        y = 32'((s << (ew + mw)) | (e << mw) | (q & ((one << mw) - 1)));
      end
    end
  endfunction

  task automatic drive(input bit h, input logic st, input logic [31:0] a, input logic [31:0] b);
    if (h) begin s16 = st; a16 = a[15:0]; b16 = b[15:0]; end
    else   begin s32 = st; a32 = a;       b32 = b;       end
  endtask

  task automatic sample(input bit h, output logic [31:0] y, output logic rdy, output logic bz,
                        output logic [31:0] fl);
    if (h) begin y = {16'd0, y16}; rdy = r16; bz = bz16; fl = {29'd0, ov16, un16, iv16}; end
    else   begin y = y32;          rdy = r32; bz = bz32; fl = {29'd0, ov32, un32, iv32}; end
  endtask

  // Runs one operation (optionally already launched) and checks latency,
  // busy profile, result and flags. A start pulse with (ca,cb) is sampled at
  // edge chain_at when chain_at is non-zero.
  task automatic run_op(input string tag, input bit h, input bit launch,
                        input logic [31:0] a, input logic [31:0] b,
                        input int chain_at, input logic [31:0] ca, input logic [31:0] cb);
    logic [31:0] ey, y, fl;
    logic rdy, bz;
    bit eo, eu, ei, esp, busy_ok, got_rdy;
    int lat, exp_lat;
    ref_mul(h ? 5 : 8, h ? 10 : 23, a, b, ey, eo, eu, ei, esp);
    exp_lat = esp ? 2 : (h ? 14 : 27);
    if (launch) begin
      drive(h, 1'b1, a, b);
      @(posedge clk); #1;
      drive(h, 1'b0, a, b);
    end
    lat = 0; busy_ok = 1; got_rdy = 0;
    y = 32'd0; fl = 32'd0; bz = 1'b0;
    while (!got_rdy && lat < 60) begin
      @(posedge clk); lat++; #1;
      if (chain_at != 0 && lat == chain_at) drive(h, 1'b0, ca, cb);
      sample(h, y, rdy, bz, fl);
      if (rdy) got_rdy = 1;
      else begin
        if (!bz) busy_ok = 0;
        if (chain_at != 0 && lat == chain_at - 1) drive(h, 1'b1, ca, cb);
      end
    end
    check_val({tag, " latency"}, lat, exp_lat);
    check_val({tag, " Y"}, y, ey);
    check_val({tag, " flags"}, fl, {29'd0, eo, eu, ei});
    check_val({tag, " busy_at_ready"}, {31'd0, bz}, 32'd0);
    check_val({tag, " busy_profile"}, {31'd0, busy_ok}, 32'd1);
  endtask

  logic [31:0] da [12] = '{32'h3FC00000, 32'hC0000000, 32'h3F800001, 32'h3FC00001,
                           32'h7F000000, 32'h00800000, 32'h7F800000, 32'hFF800000,
                           32'h80000000, 32'h7F800001, 32'h00000000, 32'h00000001};
  logic [31:0] db [12] = '{32'h40000000, 32'h40400000, 32'h3F800001, 32'h3FC00001,
                           32'h40000000, 32'h3F000000, 32'h00000000, 32'h40000000,
                           32'h40400000, 32'h3F800000, 32'h7F800000, 32'h40000000};

  initial begin
    logic [31:0] ra, rb, y, fl;
    logic rdy, bz;
    int seen;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    sample(1'b0, y, rdy, bz, fl);
    check_val("reset Y", y, 32'd0);
    check_val("reset ready", {31'd0, rdy}, 32'd0);
    check_val("reset busy", {31'd0, bz}, 32'd0);
    check_val("reset flags", fl, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_op("dir32", 1'b0, 1'b1, da[i], db[i], 0, 32'd0, 32'd0);

    for (int i = 0; i < 30; i++) begin
      if (i % 4 == 0) begin
        ra = $urandom; rb = $urandom;
      end else begin
        ra = {1'($urandom_range(0, 1)), 8'($urandom_range(60, 190)), 23'($urandom)};
        rb = {1'($urandom_range(0, 1)), 8'($urandom_range(60, 190)), 23'($urandom)};
      end
      run_op("rnd32", 1'b0, 1'b1, ra, rb, 0, 32'd0, 32'd0);
    end

    // Start while busy must be ignored; start during DONE chains directly.
    run_op("ignored", 1'b0, 1'b1, 32'h3FC00000, 32'h40000000, 10, 32'h7F800000, 32'h00000000);
    run_op("b2b_first", 1'b0, 1'b1, 32'h40400000, 32'h40400000, 27, 32'h3F800001, 32'h40000000);
    run_op("b2b_second", 1'b0, 1'b0, 32'h3F800001, 32'h40000000, 0, 32'd0, 32'd0);

    // Reset mid-operation aborts with no ready.
    drive(1'b0, 1'b1, 32'h40400000, 32'h40000000);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h40400000, 32'h40000000);
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sample(1'b0, y, rdy, bz, fl);
    check_val("midrst Y", y, 32'd0);
    check_val("midrst busy", {31'd0, bz}, 32'd0);
    check_val("midrst ready", {31'd0, rdy}, 32'd0);
    #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (r32) seen++;
    end
    check_val("midrst no_ready", seen, 0);

    run_op("dir16_a", 1'b1, 1'b1, 32'h3C00, 32'h4000, 0, 32'd0, 32'd0);
    run_op("dir16_b", 1'b1, 1'b1, 32'h7BFF, 32'h4000, 0, 32'd0, 32'd0);
    run_op("dir16_c", 1'b1, 1'b1, 32'h7C00, 32'h0000, 0, 32'd0, 32'd0);
    for (int i = 0; i < 15; i++) begin
      ra = {16'd0, 1'($urandom_range(0, 1)), 5'($urandom_range(6, 24)), 10'($urandom)};
      rb = {16'd0, 1'($urandom_range(0, 1)), 5'($urandom_range(6, 24)), 10'($urandom)};
      run_op("rnd16", 1'b1, 1'b1, ra, rb, 0, 32'd0, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
